// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared definitions for the mux_pipe_arbiter slice.
//   - Owner encoding (OWNER_A / OWNER_B).
//   - Run-length counter width and saturation value.
//   - Default payload / length widths.
//   - Selection result type and a saturating counter increment helper.
package mux_arb_pkg;

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned CNT_MAX = 15;

  localparam int unsigned DEF_WIDTH  = 128;
  localparam int unsigned DEF_LWIDTH = 16;

  typedef enum logic [1:0] {
    SelNone = 2'd0,
    SelA    = 2'd1,
    SelB    = 2'd2
  } sel_e;

  // Run counter increment that sticks at CNT_MAX instead of wrapping.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_W'(CNT_MAX)) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/mux_arb_slot.sv
// mux_arb_slot: one-entry holding register in front of the arbiter.
// Ports:
//   clk_i       clock
//   rst_i       synchronous active-high reset, empties the slot
//   enq_ena_i   write a new entry (only asserted while enq_rdy_o is high)
//   enq_v_i     payload to store
//   enq_len_i   length to store
//   deq_i       slot is drained downstream this cycle
//   valid_o     slot holds an entry
//   v_o, len_o  stored payload / length
//   enq_rdy_o   slot can accept this cycle (empty, or being drained now)
module mux_arb_slot
  import mux_arb_pkg::*;
#(
  parameter int unsigned Width  = DEF_WIDTH,
  parameter int unsigned LWidth = DEF_LWIDTH
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enq_ena_i,
  input  logic [Width-1:0]  enq_v_i,
  input  logic [LWidth-1:0] enq_len_i,
  input  logic              deq_i,
  output logic              valid_o,
  output logic [Width-1:0]  v_o,
  output logic [LWidth-1:0] len_o,
  output logic              enq_rdy_o
);

  logic              valid_q;
  logic [Width-1:0]  v_q;
  logic [LWidth-1:0] len_q;

  // Combinational through deq_i so a draining slot can refill in the same cycle.
  assign enq_rdy_o = !valid_q || deq_i;
  assign valid_o   = valid_q;
  assign v_o       = v_q;
  assign len_o     = len_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      v_q     <= '0;
      len_q   <= '0;
    end else if (enq_ena_i) begin
      // Enq wins over deq: simultaneous enq+deq keeps the slot full with new data.
      valid_q <= 1'b1;
      v_q     <= enq_v_i;
      len_q   <= enq_len_i;
    end else if (deq_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/mux_pipe_arbiter.sv
// mux_pipe_arbiter: weighted round-robin between two enq requesters (a, b) sharing one
// downstream enq port (out). Each side has a one-entry slot; the current owner keeps the
// grant for up to its weight in consecutive beats while the other side waits.
// Ports:
//   CLK, RST                       clock, synchronous active-high reset
//   a_enq__ENA/_v/_length/__RDY    requester A enq interface
//   b_enq__ENA/_v/_length/__RDY    requester B enq interface
//   out_enq__ENA/_v/_length        downstream beat (payload zero when not firing)
//   out_enq__RDY                   downstream ready
// Optional (macro MUX_PIPE_ARBITER_STATS_EN):
//   statA, statB                   beats granted per side, wrap at 2^32
//   statSwitch                     ownership changes, saturating at 16'hFFFF
module mux_pipe_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned LWIDTH   = DEF_LWIDTH,
  parameter int unsigned WEIGHT_A = 4,
  parameter int unsigned WEIGHT_B = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              a_enq__ENA,
  input  logic [WIDTH-1:0]  a_enq_v,
  input  logic [LWIDTH-1:0] a_enq_length,
  output logic              a_enq__RDY,
  input  logic              b_enq__ENA,
  input  logic [WIDTH-1:0]  b_enq_v,
  input  logic [LWIDTH-1:0] b_enq_length,
  output logic              b_enq__RDY,
  output logic              out_enq__ENA,
  output logic [WIDTH-1:0]  out_enq_v,
  output logic [LWIDTH-1:0] out_enq_length,
  input  logic              out_enq__RDY
`ifdef MUX_PIPE_ARBITER_STATS_EN
  ,
  output logic [31:0]       statA,
  output logic [31:0]       statB,
  output logic [15:0]       statSwitch
`endif
);

  localparam logic [CNT_W-1:0] WeightA = CNT_W'(WEIGHT_A);
  localparam logic [CNT_W-1:0] WeightB = CNT_W'(WEIGHT_B);

  logic              vld_a, vld_b;
  logic [WIDTH-1:0]  v_a, v_b;
  logic [LWIDTH-1:0] len_a, len_b;
  logic              deq_a, deq_b, fire;

  logic              owner_q;
  logic [CNT_W-1:0]  cnt_q;

  sel_e sel;
  logic own_is_a, own_vld, oth_vld, under_w, take_own;

  mux_arb_slot #(.Width(WIDTH), .LWidth(LWIDTH)) u_slot_a (
    .clk_i     (CLK),
    .rst_i     (RST),
    .enq_ena_i (a_enq__ENA),
    .enq_v_i   (a_enq_v),
    .enq_len_i (a_enq_length),
    .deq_i     (deq_a),
    .valid_o   (vld_a),
    .v_o       (v_a),
    .len_o     (len_a),
    .enq_rdy_o (a_enq__RDY)
  );

  mux_arb_slot #(.Width(WIDTH), .LWidth(LWIDTH)) u_slot_b (
    .clk_i     (CLK),
    .rst_i     (RST),
    .enq_ena_i (b_enq__ENA),
    .enq_v_i   (b_enq_v),
    .enq_len_i (b_enq_length),
    .deq_i     (deq_b),
    .valid_o   (vld_b),
    .v_o       (v_b),
    .len_o     (len_b),
    .enq_rdy_o (b_enq__RDY)
  );

  // Owner keeps the grant while under weight, or unconditionally if the other side is idle.
  always_comb begin
    own_is_a = (owner_q == OWNER_A);
    own_vld  = own_is_a ? vld_a : vld_b;
    oth_vld  = own_is_a ? vld_b : vld_a;
    under_w  = own_is_a ? (cnt_q < WeightA) : (cnt_q < WeightB);
    sel      = SelNone;
    take_own = 1'b0;
    if (own_vld && (under_w || !oth_vld)) begin
      sel      = own_is_a ? SelA : SelB;
      take_own = 1'b1;
    end else if (oth_vld) begin
      sel = own_is_a ? SelB : SelA;
    end
  end

  assign fire  = (sel != SelNone) && out_enq__RDY;
  assign deq_a = fire && (sel == SelA);
  assign deq_b = fire && (sel == SelB);

  assign out_enq__ENA   = fire;
  assign out_enq_v      = ({WIDTH{deq_a}} & v_a) | ({WIDTH{deq_b}} & v_b);
  assign out_enq_length = ({LWIDTH{deq_a}} & len_a) | ({LWIDTH{deq_b}} & len_b);

  // Arbitration state: frozen whenever nothing fires (including backpressure).
  always_ff @(posedge CLK) begin
    if (RST) begin
      owner_q <= OWNER_A;
      cnt_q   <= '0;
    end else if (fire) begin
      if (take_own) begin
        cnt_q <= cnt_inc(cnt_q);
      end else begin
        owner_q <= ~owner_q;
        cnt_q   <= CNT_W'(1);
      end
    end
  end

`ifdef MUX_PIPE_ARBITER_STATS_EN
  logic [31:0] stat_a_q, stat_b_q;
  logic [15:0] stat_sw_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      stat_a_q  <= '0;
      stat_b_q  <= '0;
      stat_sw_q <= '0;
    end else begin
      if (deq_a) stat_a_q <= stat_a_q + 32'd1;
      if (deq_b) stat_b_q <= stat_b_q + 32'd1;
      if (fire && !take_own && (stat_sw_q != 16'hFFFF)) stat_sw_q <= stat_sw_q + 16'd1;
    end
  end

  assign statA      = stat_a_q;
  assign statB      = stat_b_q;
  assign statSwitch = stat_sw_q;
`endif

endmodule

// File: doc/mux_pipe_arbiter.md
Name: mux_pipe_arbiter

Overview:
- Weighted round-robin arbiter that shares one downstream enq port (`out`) between two upstream enq requesters (`a`, `b`). Each requester carries a 128-bit payload and a 16-bit length.
- Each requester has its own one-entry holding slot. The grant holds on the current owner for up to its weight in beats, then rotates if the other side has data.
- Replaces fixed-priority muxing in front of shared pipes, so neither stream can starve the other.

Parameters:
- WIDTH, 128, payload width of v.
- LWIDTH, 16, width of length.
- WEIGHT_A, 4, maximum consecutive beats granted to `a` while `b` is waiting (range 1..15).
- WEIGHT_B, 4, same for `b`.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  reset, synchronous, active-high.
- a$enq__ENA  input  1  requester A enq; asserted only when a$enq__RDY is high.
- a$enq$v  input  WIDTH  A payload.
- a$enq$length  input  LWIDTH  A length.
- a$enq__RDY  output  1  A slot can accept this cycle.
- b$enq__ENA, b$enq$v, b$enq$length, b$enq__RDY: same as A, for requester B.
- out$enq__ENA  output  1  beat transferred downstream this cycle.
- out$enq$v  output  WIDTH  selected payload.
- out$enq$length  output  LWIDTH  selected length.
- out$enq__RDY  input  1  downstream can accept.

Behaviour:
- **Reset** (RST high at edge):
  - both slots empty; owner=A; cnt=0.
  - out$enq__ENA=0; out$enq$v=0; out$enq$length=0; a/b RDY=1 from the first cycle after reset.
  - Reset mid-operation discards held beats; no partial state survives.
- **Slot X (A or B):**
  - Holds valid_X, v_X, len_X.
  - X$enq__RDY = !valid_X | deqX, where deqX means the slot is drained this cycle. This is a combinational path from out$enq__RDY and is intentional.
  - Enq and deq in the same cycle leave valid_X=1 with the new data (full-rate streaming).
  - enq on a full slot cannot occur (ENA implies RDY).
- **Selection** (combinational; O=owner, N=other):
  - If valid_O && (cnt < WEIGHT_O || !valid_N): sel=O.
  - Else if valid_N: sel=N.
  - Else: sel=none.
- **Output:**
  - out$enq__ENA = (sel!=none) & out$enq__RDY.
  - v/length are the AND-OR mux of the selected slot, and all-zero when out$enq__ENA=0.
- **On fire:**
  - If sel==O: cnt <= min(cnt+1, 15).
  - If sel==N: owner <= N, cnt <= 1.
  - No fire: owner and cnt unchanged.
- **Latency:** enq to out is minimum 1 cycle; there is no bypass path.
- **Fairness bound:** with both sides continuously valid and out$enq__RDY=1, the pattern is WEIGHT_A beats A, WEIGHT_B beats B, repeating.
- **Lone requester:** gets 100% throughput; cnt saturates at 15, with no wrap.
- **Backpressure:** out$enq__RDY=0 freezes owner, cnt and slots. Selection may change while stalled (e.g. N becomes valid and O's weight is spent); this is legal.
- **Simultaneous arrival, both slots empty:** the owner side goes first.
- **Ordering:** per-requester order is always preserved.

Optional Feature:
- Macro: MUX_PIPE_ARBITER_STATS_EN.
- When defined, add output ports:
  - statA, output, 32 bits: beats granted to A; wraps modulo 2^32.
  - statB, output, 32 bits: beats granted to B; wraps modulo 2^32.
  - statSwitch, output, 16 bits: ownership changes; saturates at 0xFFFF.
  - All three clear on RST.
- When not defined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package mux_arb_pkg holds:
  - owner encoding (OWNER_A=1'b0, OWNER_B=1'b1);
  - CNT_W=4 and CNT_MAX=15;
  - default WIDTH/LWIDTH constants.
- One sub-module, mux_arb_slot: one-entry holding register with enq/deq and the RDY equation. It is instantiated twice, once for A and once for B.
- Arbitration FSM (owner, cnt) stays in the top module.

Test Plan:
1. RST for 2 cycles, then idle → out$enq__ENA=0, v=0, length=0, a$enq__RDY=b$enq__RDY=1. With STATS_EN, all counters read 0.
2. A alone sends 20 beats (v=i, length=i+100), out$enq__RDY=1 → 20 beats out in order, each 1 cycle after enq. cnt saturates at 15, with no drop and no duplicate.
3. A and B both streaming, WEIGHT_A=3, WEIGHT_B=1, 16 beats out → pattern AAAB repeated 4 times; statSwitch=7.
4. Both slots loaded in the same cycle with owner=A, out$enq__RDY held at 0 for 5 cycles → ENA=0 throughout, slots retained; on release, the A beat goes first, then B.
5. B valid, A idle; owner=A with cnt=2 → B granted immediately, owner=B, cnt=1.
6. RST asserted mid-stream with both slots full → next cycle out$enq__ENA=0, slots empty, owner=A. Beats enqueued after reset emerge unchanged.
